// File: rtl/ariane_pkg.sv
// Shared types for the performance-counter sampler.
//   perf_sample_t    : one record pushed per sampled counter
//   state_e          : sweep controller states
//   NR_PERF_COUNTERS : number of counters in the bank
package ariane_pkg;

  localparam int unsigned NR_PERF_COUNTERS = 14;

  typedef struct packed {
    logic [15:0] seq;
    logic [4:0]  idx;
    logic        last;
    logic [63:0] data;
  } perf_sample_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

endpackage

// File: rtl/perf_sampler_if.sv
// Bundles the counter-bank port and the sample output stream of perf_sampler.
//   master : sampler side (drives pc_addr/we/wdata and the sample stream)
//   slave  : counter bank + consumer side (drives pc_rdata and sample_ready)
interface perf_sampler_if;
  logic [4:0]  pc_addr_o;
  logic        pc_we_o;
  logic [63:0] pc_wdata_o;
  logic [63:0] pc_rdata_i;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic [63:0] sample_data_o;
  logic [4:0]  sample_idx_o;
  logic        sample_last_o;
  logic [15:0] sample_seq_o;

  modport master (
    output pc_addr_o, pc_we_o, pc_wdata_o,
    output sample_valid_o, sample_data_o, sample_idx_o, sample_last_o, sample_seq_o,
    input  pc_rdata_i, sample_ready_i
  );

  modport slave (
    input  pc_addr_o, pc_we_o, pc_wdata_o,
    input  sample_valid_o, sample_data_o, sample_idx_o, sample_last_o, sample_seq_o,
    output pc_rdata_i, sample_ready_i
  );
endinterface

// File: rtl/perf_sample_fifo.sv
// Small record FIFO between the sweep controller and the output stream.
//   push_i/data_i/full_o  : write side (full_o is from registered pointers)
//   pop_i/valid_o/data_o  : read side (data_o is the stored head entry)
//   rst_i                 : synchronous flush
module perf_sample_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  perf_sample_t data_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic         valid_o,
  output perf_sample_t data_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  perf_sample_t mem_q [DEPTH];
  logic         empty, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = !empty;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop_i && !empty;
  // At full a simultaneous pop frees the head slot, which the push reuses.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/perf_sampler.sv
// Periodic performance-counter sampler.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   enable_i              : period timer runs (low clears the timer)
//   debug_mode_i          : freezes the period timer
//   clear_on_read_i       : zero each counter as it is sampled
//   io (master)           : counter-bank port + sample record stream
//   busy_o                : sweep in progress
//   missed_o              : saturating count of expiries during a sweep
module perf_sampler
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS = NR_PERF_COUNTERS,
  parameter int unsigned PERIOD       = 30000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  debug_mode_i,
  input  logic                  clear_on_read_i,
  perf_sampler_if.master        io,
  output logic                  busy_o,
  output logic [7:0]            missed_o
);
  localparam int unsigned TW = $clog2(PERIOD);

  state_e       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]   idx_q, idx_d;
  logic [15:0]  seq_q, seq_d;
  logic [7:0]   missed_q, missed_d;
  logic         expiry, push, last, fifo_full;
  perf_sample_t push_rec, head;

  assign last     = (idx_q == 5'(NUM_COUNTERS - 1));
  assign push     = (state_q == SWEEP) && !fifo_full;
  assign push_rec = '{seq: seq_q, idx: idx_q, last: last, data: io.pc_rdata_i};

  always_comb begin
    timer_d = timer_q;
    expiry  = 1'b0;
    if (!enable_i) begin
      timer_d = '0;
    end else if (!debug_mode_i) begin
      if (timer_q == TW'(PERIOD - 1)) begin
        timer_d = '0;
        expiry  = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    missed_d = missed_q;
    case (state_q)
      IDLE: begin
        if (expiry) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (expiry && (missed_q != 8'hFF)) missed_d = missed_q + 8'd1;
        if (push) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
            seq_d   = seq_q + 16'd1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      missed_q <= missed_d;
    end
  end

  perf_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_rec),
    .full_o  (fifo_full),
    .pop_i   (io.sample_ready_i),
    .valid_o (io.sample_valid_o),
    .data_o  (head)
  );

  assign io.pc_addr_o     = (state_q == SWEEP) ? idx_q : 5'd0;
  // Write-after-read: the bank returns the old value this cycle, zero next.
  assign io.pc_we_o       = push && clear_on_read_i;
  assign io.pc_wdata_o    = '0;
  assign io.sample_data_o = head.data;
  assign io.sample_idx_o  = head.idx;
  assign io.sample_last_o = head.last;
  assign io.sample_seq_o  = head.seq;
  assign busy_o           = (state_q == SWEEP);
  assign missed_o         = missed_q;
endmodule

// File: tb/tb_perf_sampler.sv
module tb_perf_sampler;
  import ariane_pkg::*;

  logic clk, rst;
  logic enable_a, debug_a, clear_a, ready_a;
  logic enable_b;
  logic busy_a, busy_b;
  logic [7:0] missed_a, missed_b;
  logic bank_load, inc3;
  logic [63:0] bank [32];

  int n_cmp = 0;
  int n_bad = 0;
  perf_sample_t exp_q[$];

  perf_sampler_if bus_a ();
  perf_sampler_if bus_b ();

  initial clk = 1'b0;
  always #5 clk = ~clk;

  perf_sampler #(.NUM_COUNTERS(14), .PERIOD(20), .FIFO_DEPTH(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_a), .debug_mode_i(debug_a),
    .clear_on_read_i(clear_a), .io(bus_a), .busy_o(busy_a), .missed_o(missed_a)
  );

  perf_sampler #(.NUM_COUNTERS(14), .PERIOD(5), .FIFO_DEPTH(4)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_b), .debug_mode_i(1'b0),
    .clear_on_read_i(1'b0), .io(bus_b), .busy_o(busy_b), .missed_o(missed_b)
  );

  // Counter bank model: combinational read, write-zero wins over increment.
  assign bus_a.pc_rdata_i     = bank[bus_a.pc_addr_o];
  assign bus_a.sample_ready_i = ready_a;
  assign bus_b.pc_rdata_i     = 64'(bus_b.pc_addr_o);
  assign bus_b.sample_ready_i = 1'b0;

  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < 32; i++) bank[i] <= 64'(i * 100);
    end else begin
      if (inc3) bank[3] <= bank[3] + 64'd1;
      if (bus_a.pc_we_o) bank[bus_a.pc_addr_o] <= '0;
    end
  end

  // Scoreboard monitor: every accepted record is checked against the queue.
  always @(negedge clk) begin
    perf_sample_t got, exp;
    if (rst === 1'b0 && bus_a.sample_valid_o === 1'b1 && bus_a.sample_ready_i === 1'b1) begin
      got = '{seq: bus_a.sample_seq_o, idx: bus_a.sample_idx_o,
              last: bus_a.sample_last_o, data: bus_a.sample_data_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL record_unexpected: got seq=%0d idx=%0d last=%0d data=%0d, required none",
                 got.seq, got.idx, got.last, got.data);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_bad++;
          $display("FAIL record: got seq=%0d idx=%0d last=%0d data=%0d, required seq=%0d idx=%0d last=%0d data=%0d",
                   got.seq, got.idx, got.last, got.data, exp.seq, exp.idx, exp.last, exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input int seq, input int idx, input logic [63:0] data);
    exp_q.push_back('{seq: 16'(seq), idx: 5'(idx), last: (idx == 13), data: data});
  endtask

  // A full sweep of the preloaded bank (counter i holds i*100).
  task automatic push_sweep(input int seq);
    for (int i = 0; i < 14; i++) push_exp(seq, i, 64'(i * 100));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bank_load = 1'b1;
    tick();
    bank_load = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      if (exp_q.size() == 0 && bus_a.sample_valid_o === 1'b0) done = 1'b1;
      else tick();
    end
    chk(name, 64'(done), 64'd1);
  endtask

  initial begin
    rst = 1'b1; enable_a = 1'b0; debug_a = 1'b0; clear_a = 1'b0; ready_a = 1'b0;
    enable_b = 1'b0; bank_load = 1'b0; inc3 = 1'b0;

    // Reset state
    ticks(2);
    chk("rst_valid",  64'(bus_a.sample_valid_o), 64'd0);
    chk("rst_busy",   64'(busy_a), 64'd0);
    chk("rst_we",     64'(bus_a.pc_we_o), 64'd0);
    chk("rst_addr",   64'(bus_a.pc_addr_o), 64'd0);
    chk("rst_wdata",  bus_a.pc_wdata_o, 64'd0);
    chk("rst_missed", 64'(missed_a), 64'd0);

    // Basic sweeps: start after 20 enabled cycles, seq 0 then 1
    do_reset();
    enable_a = 1'b1; ready_a = 1'b1;
    push_sweep(0);
    push_sweep(1);
    ticks(19);
    chk("t1_busy_before", 64'(busy_a), 64'd0);
    tick();
    chk("t1_busy_start", 64'(busy_a), 64'd1);
    chk("t1_valid_first", 64'(bus_a.sample_valid_o), 64'd0);
    wait_drain("t1_drain", 200);
    enable_a = 1'b0;
    chk("t1_missed", 64'(missed_a), 64'd0);
    chk("t1_busy_end", 64'(busy_a), 64'd0);

    // Stall with ready low: four records, then address holds at 4
    ready_a = 1'b0;
    do_reset();
    enable_a = 1'b1;
    push_sweep(0);
    ticks(20);
    chk("t2_busy", 64'(busy_a), 64'd1);
    ticks(10);
    chk("t2_addr_hold", 64'(bus_a.pc_addr_o), 64'd4);
    chk("t2_we_stall", 64'(bus_a.pc_we_o), 64'd0);
    chk("t2_valid", 64'(bus_a.sample_valid_o), 64'd1);
    ticks(5);
    chk("t2_addr_hold2", 64'(bus_a.pc_addr_o), 64'd4);
    ready_a = 1'b1;
    wait_drain("t2_drain", 200);
    enable_a = 1'b0;
    chk("t2_missed", 64'(missed_a), 64'd1);

    // Clear-on-read with counter 3 incrementing every cycle
    do_reset();
    enable_a = 1'b1; ready_a = 1'b1; clear_a = 1'b1; inc3 = 1'b1;
    for (int i = 0; i < 14; i++) push_exp(0, i, (i == 3) ? 64'd323 : 64'(i * 100));
    ticks(19);
    chk("t3_we_idle", 64'(bus_a.pc_we_o), 64'd0);
    ticks(4);
    chk("t3_addr3", 64'(bus_a.pc_addr_o), 64'd3);
    chk("t3_we3", 64'(bus_a.pc_we_o), 64'd1);
    tick();
    chk("t3_bank3_zero", bank[3], 64'd0);
    tick();
    chk("t3_bank3_next", bank[3], 64'd1);
    wait_drain("t3_drain", 200);
    enable_a = 1'b0; clear_a = 1'b0; inc3 = 1'b0;

    // Missed expiries on the PERIOD=5 instance, stalled forever
    do_reset();
    enable_b = 1'b1;
    ticks(5);
    chk("t4_busy", 64'(busy_b), 64'd1);
    ticks(5);
    chk("t4_missed1", 64'(missed_b), 64'd1);
    ticks(4);
    chk("t4_missed1_hold", 64'(missed_b), 64'd1);
    tick();
    chk("t4_missed2", 64'(missed_b), 64'd2);
    ticks(5);
    chk("t4_missed3", 64'(missed_b), 64'd3);
    ticks(1255);
    chk("t4_missed254", 64'(missed_b), 64'd254);
    ticks(5);
    chk("t4_missed255", 64'(missed_b), 64'd255);
    ticks(220);
    chk("t4_missed_sat", 64'(missed_b), 64'd255);
    enable_b = 1'b0;

    // Reset mid-sweep at idx 7 with three records queued
    do_reset();
    enable_a = 1'b1; ready_a = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(0, i, 64'(i * 100));
    ticks(25);
    ready_a = 1'b0;
    ticks(2);
    chk("t5_addr7", 64'(bus_a.pc_addr_o), 64'd7);
    chk("t5_valid_pre", 64'(bus_a.sample_valid_o), 64'd1);
    rst = 1'b1;
    tick();
    chk("t5_valid", 64'(bus_a.sample_valid_o), 64'd0);
    chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_addr", 64'(bus_a.pc_addr_o), 64'd0);
    chk("t5_we", 64'(bus_a.pc_we_o), 64'd0);
    rst = 1'b0; ready_a = 1'b1;
    push_sweep(0);
    ticks(19);
    chk("t5_timer_busy_before", 64'(busy_a), 64'd0);
    tick();
    chk("t5_timer_busy_start", 64'(busy_a), 64'd1);
    wait_drain("t5_drain", 200);
    enable_a = 1'b0;

    // Debug freeze delays the start by 10 cycles
    do_reset();
    enable_a = 1'b1; ready_a = 1'b1;
    push_sweep(0);
    ticks(5);
    debug_a = 1'b1;
    ticks(10);
    debug_a = 1'b0;
    ticks(14);
    chk("t6_dbg_before", 64'(busy_a), 64'd0);
    tick();
    chk("t6_dbg_start", 64'(busy_a), 64'd1);
    wait_drain("t6_drain", 200);
    enable_a = 1'b0;

    // Enable drop at timer=15 restarts the count
    do_reset();
    enable_a = 1'b1;
    push_sweep(0);
    ticks(15);
    enable_a = 1'b0;
    tick();
    enable_a = 1'b1;
    ticks(19);
    chk("t6_en_before", 64'(busy_a), 64'd0);
    tick();
    chk("t6_en_start", 64'(busy_a), 64'd1);
    wait_drain("t6_en_drain", 200);
    enable_a = 1'b0;

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/perf_sampler.md
Name: perf_sampler

Overview:
- Downstream consumer of the performance-counter bank's SRAM-like port (5-bit addr, we, 64-bit wdata, 64-bit combinational rdata).
- Every PERIOD enabled cycles, sweeps counter indices 0..NUM_COUNTERS-1 and reads each value.
- Optionally zeroes each counter on read.
- Pushes {seq, idx, last, value} records into a small FIFO drained over a valid/ready stream toward trace/debug capture.

Parameters:
- NUM_COUNTERS, 14, counters swept per sample (indices 0..NUM_COUNTERS-1, max 32).
- PERIOD, 30000, enabled cycles between sweep starts (>=2).
- FIFO_DEPTH, 4, output record FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- enable_i  in  1  period timer runs when high
- debug_mode_i  in  1  freezes period timer when high
- clear_on_read_i  in  1  write 0 to each counter as it is sampled
- pc_addr_o  out  5  counter index to counter bank
- pc_we_o  out  1  counter bank write enable
- pc_wdata_o  out  64  counter bank write data (always 0)
- pc_rdata_i  in  64  counter bank read data (combinational from pc_addr_o)
- sample_valid_o  out  1  FIFO head valid
- sample_ready_i  in  1  consumer accepts head
- sample_data_o  out  64  counter value
- sample_idx_o  out  5  counter index
- sample_last_o  out  1  final record of a sweep
- sample_seq_o  out  16  sweep sequence number
- busy_o  out  1  sweep in progress
- missed_o  out  8  saturating count of period expiries during a busy sweep

Behaviour:
- Clock/reset: one clock, clk_i. Reset is rst_i, synchronous and active-high.
- Reset state: timer=0, state IDLE, idx=0, seq=0, FIFO empty, missed_o=0. All outputs 0: valid, busy, we, addr, wdata.
- Reset mid-sweep aborts the sweep and flushes the FIFO in the same edge.
- Timer: increments when enable_i && !debug_mode_i; otherwise holds.
  - At timer==PERIOD-1 while incrementing: timer<=0 and an expiry event fires.
  - enable_i low clears the timer to 0 next cycle.
- FSM states: IDLE, SWEEP.
  - IDLE + expiry -> SWEEP: idx<=0, busy_o=1 from the next cycle; seq increments after the sweep's last push.
  - SWEEP + expiry -> stays SWEEP; missed_o+1, saturating at 255.
  - SWEEP: pc_addr_o=idx, valid combinationally. A push occurs in any SWEEP cycle with FIFO !full. The push captures pc_rdata_i, idx, seq, last=(idx==NUM_COUNTERS-1).
  - Push with clear_on_read_i: pc_we_o=1 the same cycle (write-after-read in the bank; that cycle's increment is lost).
  - FIFO full: no push, pc_we_o=0, idx holds (stall).
  - Push with last: -> IDLE, seq<=seq+1 (wraps at 16 bits), idx<=0.
- IDLE: pc_addr_o=0, pc_we_o=0.
- enable_i and debug_mode_i do not abort an active sweep.
- Sweep latency, unstalled: first push in the first SWEEP cycle; NUM_COUNTERS consecutive pushes.
- FIFO:
  - Pop when sample_valid_o && sample_ready_i.
  - Push and pop in the same cycle are both honoured, including at full.
  - Full is computed from registered state; no push-through-when-full combinational path.
  - Head outputs are registered storage; sample_valid_o = !empty.
  - Head data is stable while valid && !ready.

Decomposition:
- Shared package ariane_pkg: typedef perf_sample_t {seq[15:0], idx[4:0], last, data[63:0]}; constant NR_PERF_COUNTERS=14.
- Sub-module perf_sample_fifo (parameterised depth, perf_sample_t payload, push/full, pop/valid, synchronous flush on rst_i).

Test Plan:
- PERIOD=20, enable high, ready high, bank preloaded with idx*100 -> sweep starts after cycle 20. 14 records idx 0..13, data 0..1300, seq=0, last only on idx 13. Next sweep seq=1.
- sample_ready_i low throughout -> exactly 4 records pushed, then pc_addr_o holds at 4, pc_we_o=0. Raising ready resumes at idx 4 with no duplicate or skipped index.
- clear_on_read_i=1, bank counter 3 incrementing every cycle -> record idx 3 carries the pre-write value; bank counter 3 reads 0 the cycle after its push.
- PERIOD=5 with ready low (sweep stalled) -> missed_o counts 1,2,3,... every 5 cycles. Forced 300 expiries -> missed_o saturates at 255.
- Assert rst_i mid-sweep at idx 7 with 3 records queued -> next cycle valid=0, busy=0, pc_addr_o=0, seq=0, timer=0.
- Toggle debug_mode_i high for 10 cycles during timer count -> sweep start delayed by exactly 10 cycles. enable_i low at timer=15 -> timer restarts from 0.
